joybus_device_responder: RTL and testbench
==========================================

Name: joybus_device_responder

Overview:
Emulated N64 standard controller that answers on the single-wire joybus. It decodes console command frames, then transmits the matching response frame with joybus bit timing. It is the device-side counterpart to the PIF controller master (N64_controller_top). It lets benches and loopback builds exercise the PIF joy1..joy4 ports without a physical pad.

Parameters:
CLKS_PER_US, 16, system clocks per 1 us joybus time unit (minimum 4).
REPLY_DELAY_US, 2, idle time between the console stop bit and the first response bit.
TIMEOUT_US, 64, maximum wait for the next falling edge, or maximum low time, before a frame is abandoned.

Ports:
clk  input  1  system clock.
reset_l  input  1  asynchronous active-low reset.
joy_in  input  1  raw joybus line level (external pull-up, asynchronous).
joy_oe  output  1  1 = drive the line low (open-drain). The line is released whenever this is 0.
buttons  input  16  button word; bit 15 = A … bit 0 = C-right, in joybus order.
stick_x  input  8  signed X axis.
stick_y  input  8  signed Y axis.
pak_present  input  1  1 = accessory pak inserted.
cmd_strobe  output  1  one-cycle pulse when a valid command byte and its stop bit have been received.
cmd_code  output  8  last decoded command byte; held until the next cmd_strobe.
busy  output  1  high from the first received falling edge until the response stop bit completes or the frame is abandoned.

Behaviour:
- Reset values: joy_oe=0, cmd_strobe=0, cmd_code=0x00, busy=0, FSM=IDLE, all counters 0. Asserting reset mid-frame releases the line immediately.
- joy_in passes through a 2-FF synchroniser. Falling-edge detection uses the synchronised value. Received timing is therefore delayed 2 clocks; this is acceptable.
- Time unit U = CLKS_PER_US clocks.
- FSM states: IDLE, RX_BIT, RX_STOP, DELAY, TX_LOW, TX_HIGH, TX_STOP, DRAIN.
- IDLE: on a falling edge, go to RX_BIT with bit_cnt=0 and busy=1.
- RX_BIT: sample the synchronised line 2U after the falling edge. Low → 0, high → 1. Shift in MSB first.
  - After 8 bits, wait for the next falling edge → RX_STOP.
  - If no falling edge arrives within TIMEOUT_US, or the line stays low longer than TIMEOUT_US → DRAIN.
- RX_STOP: sample 2U after the falling edge.
  - High (console stop, nominal 1U low) → latch cmd_code, pulse cmd_strobe, go to DELAY.
  - Low → DRAIN. This covers a command byte longer than 1 byte, e.g. 0x02/0x03 pak commands. Those commands are unsupported and receive no reply.
- DELAY: count REPLY_DELAY_US·U clocks. At entry, snapshot the response for the decoded command into a 32-bit tx shift register and set tx_len:
  - Commands 0x00 and 0xFF: 3 bytes. Byte 0 = 0x05, byte 1 = 0x00, byte 2 = 0x01 if pak_present else 0x02.
  - Command 0x01: 4 bytes. buttons[15:8], buttons[7:0], stick_x, stick_y.
  - Any other code: no reply. busy drops and the FSM goes to IDLE after DELAY.
  - Inputs that change during transmission do not affect the frame already in flight.
- TX bit, MSB first, 4U total per bit:
  - Bit 0 = 3U low (TX_LOW) then 1U released (TX_HIGH).
  - Bit 1 = 1U low then 3U released.
- TX_STOP: after the last bit, drive low 2U, then release. Busy drops 1 clock after release → IDLE.
- DRAIN: line released. Wait until the line has been continuously high for TIMEOUT_US, then → IDLE with busy=0. No cmd_strobe is issued.
- While transmitting, falling edges are ignored, including the device's own driven edges.
- Counters must be wide enough for TIMEOUT_US·CLKS_PER_US. The timer is saturating; it never wraps.

Test Plan:
- Console sends 0x00 plus stop, pak_present=0, CLKS_PER_US=16 → cmd_strobe once with cmd_code=0x00. After 32 idle clocks (plus 2 synchroniser clocks), response bytes 05 00 02 with exact low widths of 48/16 clocks, then a 32-clock stop low.
- Console sends 0x01 with buttons=0x8001, stick_x=0x7F, stick_y=0x80 → reply 80 01 7F 80. Changing buttons mid-reply does not alter the transmitted bits.
- Console sends 0xFF with pak_present=1 → reply 05 00 01. busy stays high from the first edge through the stop bit.
- Console sends 0x02 followed by more bits → no cmd_strobe, joy_oe stays 0, FSM reaches DRAIN and returns to IDLE after 64 µs high.
- Console stops after 5 bits → timeout at 64 µs, DRAIN, IDLE. The next valid 0x00 frame is answered normally.
- reset_l asserted during TX_LOW → joy_oe=0 asynchronously and busy=0. After release, a fresh 0x01 frame is decoded correctly.

Source files
------------

// File: rtl/joybus_device_responder.sv
// Emulated N64 standard controller on the single-wire joybus.
// Decodes a one-byte console command and replies with joybus bit timing.
module joybus_device_responder #(
    parameter int CLKS_PER_US    = 16,
    parameter int REPLY_DELAY_US = 2,
    parameter int TIMEOUT_US     = 64
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        joy_in,
    output logic        joy_oe,
    input  logic [15:0] buttons,
    input  logic [7:0]  stick_x,
    input  logic [7:0]  stick_y,
    input  logic        pak_present,
    output logic        cmd_strobe,
    output logic [7:0]  cmd_code,
    output logic        busy
);

    localparam int U_CLKS   = CLKS_PER_US;
    localparam int TO_CLKS  = TIMEOUT_US * CLKS_PER_US;
    localparam int DL_CLKS  = REPLY_DELAY_US * CLKS_PER_US;
    localparam int MAX_A    = (TO_CLKS > DL_CLKS) ? TO_CLKS : DL_CLKS;
    localparam int MAX_CLKS = (MAX_A > 4 * U_CLKS) ? MAX_A : 4 * U_CLKS;
    localparam int TW       = $clog2(MAX_CLKS + 1) + 1;

    localparam logic [TW-1:0] C_1U_M1 = TW'(U_CLKS - 1);
    localparam logic [TW-1:0] C_2U_M1 = TW'(2 * U_CLKS - 1);
    localparam logic [TW-1:0] C_2U    = TW'(2 * U_CLKS);
    localparam logic [TW-1:0] C_3U_M1 = TW'(3 * U_CLKS - 1);
    localparam logic [TW-1:0] C_DL_M1 = TW'(DL_CLKS - 1);
    localparam logic [TW-1:0] C_TO    = TW'(TO_CLKS);
    localparam logic [TW-1:0] C_TO_M1 = TW'(TO_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_BIT,
        S_RX_STOP,
        S_DELAY,
        S_TX_LOW,
        S_TX_HIGH,
        S_TX_STOP,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [TW-1:0]   r_tmr;
    logic [3:0]      r_bit_cnt;
    logic            r_sampled;
    logic [7:0]      r_rx;
    logic [31:0]     r_tx;
    logic [5:0]      r_bits;
    logic            r_oe;
    logic            r_strobe;
    logic [7:0]      r_cmd;
    logic            r_busy;

    logic            w_fall;
    logic [31:0]     w_resp;
    logic [5:0]      w_len;

    assign w_fall     = r_prev & ~r_sync2;
    assign joy_oe     = r_oe;
    assign cmd_strobe = r_strobe;
    assign cmd_code   = r_cmd;
    assign busy       = r_busy;

    // Response image is left-aligned so the MSB is always the next bit out
    always_comb begin
        w_resp = '0;
        w_len  = '0;
        case (r_rx)
            8'h00, 8'hFF: begin
                w_resp = {8'h05, 8'h00, (pak_present ? 8'h01 : 8'h02), 8'h00};
                w_len  = 6'd24;
            end
            8'h01: begin
                w_resp = {buttons, stick_x, stick_y};
                w_len  = 6'd32;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state   <= S_IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_prev    <= 1'b1;
            r_tmr     <= '0;
            r_bit_cnt <= '0;
            r_sampled <= 1'b0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_bits    <= '0;
            r_oe      <= 1'b0;
            r_strobe  <= 1'b0;
            r_cmd     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_sync1  <= joy_in;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_strobe <= 1'b0;
            if (r_tmr != '1) r_tmr <= r_tmr + TW'(1);
            unique case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state   <= S_RX_BIT;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_sampled <= 1'b0;
                        r_tmr     <= '0;
                    end
                end
                S_RX_BIT: begin
                    if (w_fall && r_sampled) begin
                        r_tmr     <= '0;
                        r_sampled <= 1'b0;
                        if (r_bit_cnt == 4'd8) r_state <= S_RX_STOP;
                    end else if (!r_sampled && r_tmr == C_2U) begin
                        r_rx      <= {r_rx[6:0], r_sync2};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_sampled <= 1'b1;
                    end else if (r_tmr >= C_TO) begin
                        r_state <= S_DRAIN;
                        r_tmr   <= '0;
                    end
                end
                S_RX_STOP: begin
                    if (r_tmr == C_2U) begin
                        r_tmr <= '0;
                        if (r_sync2) begin
                            r_cmd    <= r_rx;
                            r_strobe <= 1'b1;
                            r_tx     <= w_resp;
                            r_bits   <= w_len;
                            r_state  <= S_DELAY;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DELAY: begin
                    if (r_tmr == C_DL_M1) begin
                        r_tmr <= '0;
                        if (r_bits == 6'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_TX_LOW;
                            r_oe    <= 1'b1;
                        end
                    end
                end
                S_TX_LOW: begin
                    if (r_tmr == (r_tx[31] ? C_1U_M1 : C_3U_M1)) begin
                        r_oe    <= 1'b0;
                        r_tmr   <= '0;
                        r_state <= S_TX_HIGH;
                    end
                end
                S_TX_HIGH: begin
                    if (r_tmr == (r_tx[31] ? C_3U_M1 : C_1U_M1)) begin
                        r_oe    <= 1'b1;
                        r_tmr   <= '0;
                        r_tx    <= {r_tx[30:0], 1'b0};
                        r_bits  <= r_bits - 6'd1;
                        r_state <= (r_bits == 6'd1) ? S_TX_STOP : S_TX_LOW;
                    end
                end
                S_TX_STOP: begin
                    if (r_tmr == C_2U_M1) begin
                        r_oe <= 1'b0;
                    end else if (r_tmr == C_2U) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    r_oe <= 1'b0;
                    if (!r_sync2) begin
                        r_tmr <= '0;
                    end else if (r_tmr >= C_TO_M1) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_joybus_device_responder.sv
// Bench for joybus_device_responder: console frames in, reply frames decoded
// from joy_oe pulse widths and checked against a queue of expected replies.
module tb_joybus_device_responder;

    localparam int U = 16;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        con_low = 1'b0;
    logic        joy_in;
    logic        joy_oe;
    logic [15:0] buttons = '0;
    logic [7:0]  stick_x = '0;
    logic [7:0]  stick_y = '0;
    logic        pak_present = 1'b0;
    logic        cmd_strobe;
    logic [7:0]  cmd_code;
    logic        busy;

    assign joy_in = ~(joy_oe | con_low);

    always #5 clk = ~clk;

    joybus_device_responder #(
        .CLKS_PER_US(U),
        .REPLY_DELAY_US(2),
        .TIMEOUT_US(64)
    ) dut (
        .clk(clk),
        .reset_l(reset_l),
        .joy_in(joy_in),
        .joy_oe(joy_oe),
        .buttons(buttons),
        .stick_x(stick_x),
        .stick_y(stick_y),
        .pak_present(pak_present),
        .cmd_strobe(cmd_strobe),
        .cmd_code(cmd_code),
        .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  q_cmd[$];
    logic [31:0] q_rdata[$];
    int          q_rlen[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: reply bytes as a controller would send them, right-aligned
    function automatic void model(input logic [7:0] c,
                                  output logic [31:0] d, output int n);
        d = '0;
        n = 0;
        if (c == 8'h00 || c == 8'hFF) begin
            d = {8'h00, 8'h05, 8'h00, (pak_present ? 8'h01 : 8'h02)};
            n = 3;
        end else if (c == 8'h01) begin
            d = {buttons, stick_x, stick_y};
            n = 4;
        end
    endfunction

    // Command strobe monitor
    always @(negedge clk) begin
        if (reset_l && cmd_strobe) begin
            if (q_cmd.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL strobe_unexpected actual=%0h required=none",
                         cmd_code);
            end else begin
                chk("cmd_code", cmd_code, q_cmd.pop_front());
            end
        end
    end

    // Reply monitor: decodes joy_oe pulse widths into bits and frames
    int          lo_w = 0;
    int          hi_w = 0;
    int          last_lo = 0;
    int          nb = 0;
    logic [31:0] acc = '0;
    logic        p_oe = 1'b0;

    always @(negedge clk) begin
        if (!reset_l) begin
            lo_w = 0;
            hi_w = 0;
            nb   = 0;
            acc  = '0;
            p_oe = 1'b0;
        end else begin
            if (joy_oe && !p_oe) begin
                if (nb > 0) chk("bit_period", hi_w + last_lo, 4 * U);
                lo_w = 1;
            end else if (joy_oe) begin
                lo_w++;
            end else if (p_oe) begin
                last_lo = lo_w;
                hi_w = 1;
                if (lo_w == U) begin
                    acc = {acc[30:0], 1'b1};
                    nb++;
                end else if (lo_w == 3 * U) begin
                    acc = {acc[30:0], 1'b0};
                    nb++;
                end else if (lo_w == 2 * U) begin
                    chk("busy_at_stop", busy, 1);
                    if (q_rlen.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL reply_unexpected actual=%0h required=none",
                                 acc);
                    end else begin
                        chk("reply_bits", nb, q_rlen.pop_front() * 8);
                        chk("reply_data", acc, q_rdata.pop_front());
                    end
                    nb  = 0;
                    acc = '0;
                end else begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pulse_width actual=%0d required=16/32/48",
                             lo_w);
                end
            end else begin
                hi_w++;
            end
            p_oe = joy_oe;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        con_low = 1'b1;
        wait_n(b ? U : 3 * U);
        con_low = 1'b0;
        wait_n(b ? 3 * U : U);
    endtask

    task automatic randomize_inputs();
        buttons     = 16'($urandom);
        stick_x     = 8'($urandom);
        stick_y     = 8'($urandom);
        pak_present = 1'($urandom);
    endtask

    // Push expectations, then drive the console frame
    task automatic frame(input logic [7:0] c, input int nbits,
                         input bit stop, input bit extra);
        logic [31:0] d;
        int          n;
        logic [7:0]  x;
        if (stop && !extra && nbits == 8) begin
            q_cmd.push_back(c);
            model(c, d, n);
            if (n > 0) begin
                q_rdata.push_back(d);
                q_rlen.push_back(n);
            end
        end
        for (int i = 0; i < nbits; i++) begin
            send_bit(c[7-i]);
            if (i == 0) chk("busy_rx", busy, 1);
        end
        if (extra) begin
            x = 8'($urandom) & 8'h7F;
            for (int i = 0; i < 8; i++) send_bit(x[7-i]);
        end
        if (stop) begin
            con_low = 1'b1;
            wait_n(U);
            con_low = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit scramble);
        int  t;
        bit  seen;
        t = 0;
        seen = 1'b0;
        wait_n(4);
        while (busy && t < 8000) begin
            @(negedge clk);
            t++;
            if (scramble && joy_oe && !seen) begin
                seen = 1'b1;
                wait_n(U);
                randomize_inputs();
            end
        end
        chk("idle_busy", busy, 0);
        chk("idle_oe", joy_oe, 0);
        wait_n(40);
    endtask

    logic [7:0] rc;
    int         kind;
    int         t;

    initial begin
        reset_l = 1'b0;
        wait_n(4);
        chk("rst_oe", joy_oe, 0);
        chk("rst_strobe", cmd_strobe, 0);
        chk("rst_code", cmd_code, 0);
        chk("rst_busy", busy, 0);
        reset_l = 1'b1;
        wait_n(20);

        pak_present = 1'b0;
        frame(8'h00, 8, 1'b1, 1'b0);
        wait_idle(1'b0);

        buttons = 16'h8001;
        stick_x = 8'h7F;
        stick_y = 8'h80;
        frame(8'h01, 8, 1'b1, 1'b0);
        wait_idle(1'b1);

        pak_present = 1'b1;
        frame(8'hFF, 8, 1'b1, 1'b0);
        wait_idle(1'b0);

        frame(8'h02, 8, 1'b1, 1'b1);
        wait_idle(1'b0);

        frame(8'($urandom), 5, 1'b0, 1'b0);
        wait_idle(1'b0);
        frame(8'h00, 8, 1'b1, 1'b0);
        wait_idle(1'b0);

        // Reset while the first reply bit is being driven
        randomize_inputs();
        frame(8'h01, 8, 1'b1, 1'b0);
        t = 0;
        while (!joy_oe && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("tx_started", joy_oe, 1);
        repeat (5) @(posedge clk);
        #2 reset_l = 1'b0;
        #1;
        chk("async_rst_oe", joy_oe, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_code", cmd_code, 0);
        q_rdata.delete();
        q_rlen.delete();
        wait_n(3);
        reset_l = 1'b1;
        wait_n(40);
        randomize_inputs();
        frame(8'h01, 8, 1'b1, 1'b0);
        wait_idle(1'b1);

        for (int k = 0; k < 12; k++) begin
            randomize_inputs();
            kind = $urandom_range(0, 5);
            case (kind)
                0: frame(8'h00, 8, 1'b1, 1'b0);
                1: frame(8'h01, 8, 1'b1, 1'b0);
                2: frame(8'hFF, 8, 1'b1, 1'b0);
                3: begin
                    do rc = 8'($urandom);
                    while (rc == 8'h00 || rc == 8'h01 || rc == 8'hFF);
                    frame(rc, 8, 1'b1, 1'b0);
                end
                4: frame(8'($urandom_range(2, 3)), 8, 1'b1, 1'b1);
                default: frame(8'($urandom), $urandom_range(1, 7), 1'b0, 1'b0);
            endcase
            wait_idle(1'b1);
        end

        chk("cmd_queue_left", q_cmd.size(), 0);
        chk("reply_queue_left", q_rlen.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
